// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: priority scheduler (alarm > chime > set > idle) driving led_itf; define ALARM_SNOOZE_EN for snooze.
module led_seq_ctrl #(
  parameter int STEP_CYC    = 25_000_000,
  parameter int CHIME_CYC   = 150_000_000,
  parameter int ALARM_STEPS = 120,
  parameter int SNOOZE_CYC  = 500_000_000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       alarm_req,
  input  logic       alarm_ack,
  input  logic       chime_pulse,
  input  logic       set_mode,
  input  logic [1:0] set_field,
  input  logic [9:0] idle_mask,
  input  logic       snooze,
  output logic [9:0] twinkle_fre,
  output logic [9:0] twinkle_led,
  output logic [9:0] valid_led,
  output logic [9:0] lin,
  output logic [1:0] active_src,
  output logic       busy
);
  localparam int M1 = STEP_CYC > CHIME_CYC ? STEP_CYC : CHIME_CYC;
  localparam int MAXC = M1 > SNOOZE_CYC ? M1 : SNOOZE_CYC;
  localparam int W = $clog2(MAXC + 1);
  localparam int SW = $clog2(ALARM_STEPS + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SETIND = 2'd1, CHIME = 2'd2, ALARM = 2'd3} state_t;
  state_t state, rest, arb;
  logic [W-1:0] cnt;
  logic [3:0] pos;
  logic [SW-1:0] steps;
  logic chime_pend, alarm_lock, chime_req, alarm_ok, step_done, alarm_end, snz_hit, snz_ok;
  logic [9:0] chase, grp;
`ifdef ALARM_SNOOZE_EN
  logic [W-1:0] snz;
  assign snz_ok = snz == '0;
  assign snz_hit = snooze;
  always_ff @(posedge sysclk)
    if (rst || alarm_ack) snz <= '0;
    else if (state == ALARM && snooze) snz <= W'(SNOOZE_CYC);
    else if (snz != '0) snz <= snz - 1'b1;
`else
  assign snz_ok = 1'b1;
  assign snz_hit = snooze & 1'b0;
`endif
  assign chime_req = chime_pend | (chime_pulse && state != CHIME);
  assign alarm_ok = alarm_req && !alarm_lock && !alarm_ack && snz_ok;
  assign rest = chime_req ? CHIME : set_mode ? SETIND : IDLE;
  assign arb = alarm_ok ? ALARM : rest;
  assign step_done = cnt == W'(STEP_CYC - 1);
  assign alarm_end = alarm_ack || !alarm_req || (step_done && steps == SW'(ALARM_STEPS - 1));
  assign chase = 10'd1 << pos;
  assign grp = set_field == 2'd0 ? 10'h003 : set_field == 2'd1 ? 10'h01C : set_field == 2'd2 ? 10'h0E0 : 10'h000;
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pos <= '0;
      steps <= '0;
      chime_pend <= 1'b0;
      alarm_lock <= 1'b0;
    end else begin
      chime_pend <= chime_req;
      if (!alarm_req) alarm_lock <= 1'b0;
      if (alarm_req && alarm_ack) alarm_lock <= 1'b1;
      case (state)
        IDLE, SETIND: begin
          state <= arb;
          cnt <= '0;
          pos <= '0;
          if (!alarm_req) steps <= '0;
          if (arb == CHIME) chime_pend <= 1'b0;
        end
        CHIME:
          if (alarm_ok) begin
            state <= ALARM;
            cnt <= '0;
            pos <= '0;
          end else if (cnt == W'(CHIME_CYC - 1)) begin
            state <= rest;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        ALARM:
          if (alarm_end) begin
            state <= rest;
            cnt <= '0;
            steps <= '0;
            alarm_lock <= alarm_req;
            if (rest == CHIME) chime_pend <= 1'b0;
          end else if (snz_hit) begin
            // snooze keeps the step count so the 60 s budget spans re-entries
            state <= rest;
            cnt <= '0;
            if (rest == CHIME) chime_pend <= 1'b0;
          end else if (step_done) begin
            cnt <= '0;
            pos <= pos == 4'd9 ? 4'd0 : pos + 4'd1;
            steps <= steps + 1'b1;
          end else cnt <= cnt + 1'b1;
      endcase
    end
  end
  always_ff @(posedge sysclk) begin
    if (rst) begin
      twinkle_fre <= 10'h004;
      twinkle_led <= '0;
      valid_led <= '0;
      lin <= '0;
      active_src <= 2'd0;
      busy <= 1'b0;
    end else begin
      active_src <= state;
      busy <= state[1];
      twinkle_fre <= state == ALARM ? 10'h001 : state == CHIME ? 10'h002 : 10'h004;
      valid_led <= state == ALARM ? chase : state == CHIME ? 10'h3FF : state == SETIND ? grp : idle_mask;
      twinkle_led <= state == ALARM ? chase : state == CHIME ? 10'h3FF : state == SETIND ? grp : 10'h000;
      lin <= state == ALARM ? chase : state == IDLE ? idle_mask : 10'h3FF;
    end
  end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: scoreboard bench; expected output vectors are queued per cycle and checked by a monitor.
module tb_led_seq_ctrl;
  logic sysclk = 0, rst, alarm_req, alarm_ack, chime_pulse, set_mode, snooze;
  logic [1:0] set_field;
  logic [9:0] idle_mask;
  logic [9:0] twinkle_fre, twinkle_led, valid_led, lin;
  logic [1:0] active_src;
  logic busy;
  int cyc = 0, passed = 0, total = 0;
  typedef struct {int cyc; string name; logic [42:0] v;} exp_t;
  exp_t q[$];
  led_seq_ctrl #(.STEP_CYC(4), .CHIME_CYC(20), .ALARM_STEPS(12), .SNOOZE_CYC(10)) dut (
    .sysclk(sysclk), .rst(rst), .alarm_req(alarm_req), .alarm_ack(alarm_ack),
    .chime_pulse(chime_pulse), .set_mode(set_mode), .set_field(set_field),
    .idle_mask(idle_mask), .snooze(snooze), .twinkle_fre(twinkle_fre),
    .twinkle_led(twinkle_led), .valid_led(valid_led), .lin(lin),
    .active_src(active_src), .busy(busy));
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  function automatic logic [42:0] o(input logic [9:0] f, t, v, l, input logic [1:0] s, input logic b);
    return {f, t, v, l, s, b};
  endfunction
  function automatic logic [42:0] al(input int p);
    logic [9:0] m;
    m = 10'd1 << p;
    return o(10'h001, m, m, m, 2'd3, 1'b1);
  endfunction
  logic [42:0] rst_o, idle_o, ch_o;
  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask
  task automatic want(input int d, input string n, input logic [42:0] v);
    int i;
    i = q.size();
    while (i > 0 && q[i-1].cyc > cyc + d) i--;
    q.insert(i, '{cyc + d, n, v});
  endtask
  always @(negedge sysclk) begin
    exp_t e;
    logic [42:0] got;
    got = {twinkle_fre, twinkle_led, valid_led, lin, active_src, busy};
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.cyc == cyc && got == e.v) passed++;
      else $display("FAIL %s cyc=%0d got=%h want=%h (fre,tl,vl,lin,src,busy)", e.name, cyc, got, e.v);
    end
  end
  initial begin
    rst_o = o(10'h004, 10'h000, 10'h000, 10'h000, 2'd0, 1'b0);
    idle_o = o(10'h004, 10'h000, 10'h155, 10'h155, 2'd0, 1'b0);
    ch_o = o(10'h002, 10'h3FF, 10'h3FF, 10'h3FF, 2'd2, 1'b1);
    rst = 1; alarm_req = 0; alarm_ack = 0; chime_pulse = 0; set_mode = 0;
    set_field = 0; idle_mask = 10'h155; snooze = 0;
    step(3);
    want(0, "reset", rst_o);
    rst = 0;
    want(1, "idle", idle_o);
    step(2);
    set_mode = 1; set_field = 1;
    want(1, "set_lag", idle_o);
    want(2, "set_min", o(10'h004, 10'h01C, 10'h01C, 10'h3FF, 2'd1, 1'b0));
    step(2);
    set_field = 2;
    want(1, "set_hour", o(10'h004, 10'h0E0, 10'h0E0, 10'h3FF, 2'd1, 1'b0));
    step(1);
    set_field = 3;
    want(1, "set_none", o(10'h004, 10'h000, 10'h000, 10'h3FF, 2'd1, 1'b0));
    step(1);
    set_field = 0; set_mode = 0;
    want(1, "set_sec", o(10'h004, 10'h003, 10'h003, 10'h3FF, 2'd1, 1'b0));
    want(2, "set_exit", idle_o);
    step(3);
    chime_pulse = 1;
    want(1, "chime_lag", idle_o);
    for (int d = 2; d <= 21; d++) want(d, "chime", ch_o);
    want(22, "chime_end", idle_o);
    step(1);
    chime_pulse = 0;
    step(25);
    alarm_req = 1;
    want(1, "alarm_lag", idle_o);
    for (int d = 2; d <= 49; d++) want(d, "chaser", al(((d - 2) / 4) % 10));
    want(50, "alarm_done", idle_o);
    want(56, "alarm_locked", idle_o);
    step(56);
    alarm_req = 0;
    step(2);
    alarm_req = 1;
    want(2, "rearm", al(0));
    want(10, "alarm_before_ack", al(2));
    want(11, "chime_after_alarm", ch_o);
    want(30, "chime_tail", ch_o);
    want(31, "single_chime", idle_o);
    want(36, "ack_locked", idle_o);
    step(3);
    chime_pulse = 1;
    step(1);
    chime_pulse = 0;
    step(2);
    chime_pulse = 1;
    step(1);
    chime_pulse = 0;
    step(2);
    alarm_ack = 1;
    step(1);
    alarm_ack = 0;
    step(30);
    alarm_req = 0;
    step(2);
    alarm_req = 1; alarm_ack = 1;
    want(2, "ack_wins", idle_o);
    want(5, "ack_lock", idle_o);
    step(1);
    alarm_ack = 0;
    step(6);
    alarm_req = 0;
    step(2);
    alarm_req = 1;
    want(2, "alarm_pre_rst", al(0));
    step(5);
    rst = 1;
    want(1, "mid_rst", rst_o);
    step(1);
    rst = 0;
    want(2, "post_rst", al(0));
    step(2);
    snooze = 1;
`ifdef ALARM_SNOOZE_EN
    want(2, "snoozed", idle_o);
    want(12, "snooze_hold", idle_o);
    want(13, "snooze_rearm", al(0));
`else
    want(2, "snooze_ignored", al(0));
    want(4, "snooze_ignored2", al(1));
`endif
    step(1);
    snooze = 0;
    step(15);
    alarm_req = 0;
    step(3);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge sysclk);
    if (q.size() != 0) begin
      $display("FAIL drain pending=%0d want=0", q.size());
      total++;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Scheduler that owns the control and data inputs of led_itf: twinkle_fre, twinkle_led, valid_led and l9..l0.
- Arbitrates three requesters by fixed priority: alarm > hourly chime > time-setting indicator > idle display.
- Generates a time-based pattern for each requester.
- Sits between the clock core (alarm/chime/set-mode logic) and led_itf.

Parameters:
- STEP_CYC, 25_000_000, sysclk cycles per alarm chaser step (0.5 s at 50 MHz).
- CHIME_CYC, 150_000_000, chime display duration in cycles (3 s).
- ALARM_STEPS, 120, chaser steps before the alarm self-terminates (60 s).
- SNOOZE_CYC, 500_000_000, snooze hold-off in cycles (10 s; optional feature only).

Ports:
- sysclk  in  1  system clock
- rst  in  1  reset
- alarm_req  in  1  level; alarm condition active
- alarm_ack  in  1  1-cycle pulse; user stops the alarm
- chime_pulse  in  1  1-cycle pulse; top of hour
- set_mode  in  1  level; clock in time-setting mode
- set_field  in  2  field under edit: 0=sec, 1=min, 2=hour, 3=reserved
- idle_mask  in  10  steady LED pattern shown in IDLE
- snooze  in  1  1-cycle pulse; used only with ALARM_SNOOZE_EN
- twinkle_fre  out  10  one-hot blink period select, to led_itf
- twinkle_led  out  10  per-LED blink enable
- valid_led  out  10  per-LED enable
- lin  out  10  LED data, bit i to l(i)
- active_src  out  2  0=idle, 1=set, 2=chime, 3=alarm
- busy  out  1  alarm or chime being displayed

Behaviour:
- Interface: one clock sysclk; reset rst is synchronous and active-high.
- All outputs are registered. Reset values:
  - twinkle_fre = 10'b00000_00100 (1.0 s)
  - twinkle_led = 0, valid_led = 0, lin = 0
  - active_src = 0, busy = 0
  - FSM in IDLE, all counters 0, chime_pend = 0.
- Output timing: outputs reflect the new state one cycle after the state register changes. A request sampled in cycle N gives changed outputs at N+2.
- FSM states: IDLE, SETIND, CHIME, ALARM.
- Priority is re-evaluated every cycle from IDLE or SETIND:
  - alarm_req -> ALARM
  - else chime_pend -> CHIME
  - else set_mode -> SETIND
  - else IDLE.
- IDLE outputs: valid_led = idle_mask, lin = idle_mask, twinkle_led = 0, twinkle_fre = 1.0 s.
- SETIND outputs:
  - LED group per field: sec = bits 1:0, min = bits 4:2, hour = bits 7:5; set_field=3 selects no group.
  - valid_led = group mask, twinkle_led = group mask, lin = all 1, twinkle_fre = 10'b00000_00100.
  - Exit when set_mode falls, or preempt by the priority rule.
- CHIME:
  - Entry clears chime_pend and the chime counter.
  - Outputs: valid_led = 10'h3FF, twinkle_led = 10'h3FF, lin = all 1, twinkle_fre = 10'b00000_00010 (0.5 s).
  - Exit when counter == CHIME_CYC-1, then re-arbitrate.
  - alarm_req during CHIME -> ALARM immediately; the chime is discarded, not re-pended.
  - chime_pulse during CHIME is ignored.
- ALARM:
  - Chaser: exactly one lin/valid_led bit is set, at position pos.
  - pos starts at 0 on entry and advances every STEP_CYC cycles; after 9 it wraps to 0.
  - twinkle_led = valid_led, twinkle_fre = 10'b00000_00001 (0.2 s).
  - Step counter counts completed steps.
  - Exit when any of these occurs: alarm_ack, alarm_req low, or step count == ALARM_STEPS.
  - On exit, set alarm_lock, which blocks re-entry until alarm_req goes low. This prevents retrigger by the same alarm level.
- chime_pend:
  - Set by chime_pulse in any state except CHIME.
  - One-deep: further pulses while pending are merged.
  - A chime pending during ALARM is served after ALARM exits.
- Simultaneous events:
  - alarm_ack and alarm_req rising in the same cycle as entry: ack wins, no ALARM entry, lock set.
  - chime_pulse in the same cycle as CHIME exit: pulse ignored.
- Counter widths are ceil(log2) of the largest parameter (29 bits at defaults). No overflow is possible.
- busy = 1 in CHIME or ALARM.
- rst asserted mid-operation returns to reset values on the next edge and clears alarm_lock.

Optional Feature:
- Macro: ALARM_SNOOZE_EN
- Defined:
  - snooze in ALARM exits to re-arbitration and loads the snooze counter with SNOOZE_CYC.
  - While the snooze counter is nonzero, ALARM entry is blocked and no lock is set.
  - When the counter reaches 0 and alarm_req is still high, ALARM re-enters with pos = 0 and the step count preserved.
  - alarm_ack clears the snooze counter and sets the lock.
- Undefined: the snooze port exists but is ignored, and no snooze counter is synthesized.

Test Plan:
1. Reset, then idle_mask = 10'h155 -> valid_led = lin = 10'h155, twinkle_led = 0, active_src = 0.
2. set_mode = 1, set_field = 1 -> after 2 cycles, valid_led = twinkle_led = 10'h01C, twinkle_fre = 10'h004, active_src = 1. set_mode = 0 -> IDLE outputs.
3. CHIME_CYC = 20: chime_pulse -> all 10 LEDs blink at fre 10'h002 for exactly 20 cycles, busy = 1, then IDLE.
4. STEP_CYC = 4, ALARM_STEPS = 12, alarm_req held high:
   - lin = 1, 2, 4 ... 10'h200, then wraps to 1.
   - Exit after 48 cycles in ALARM.
   - No re-entry until alarm_req toggles low then high.
5. Chime pulse during alarm, then alarm_ack -> CHIME entered immediately after the alarm exits; a second chime pulse during the alarm does not cause a second chime.
6. ALARM_SNOOZE_EN defined, SNOOZE_CYC = 10: snooze in ALARM -> IDLE for 10 cycles, then ALARM re-entered with lin = 1. Also: rst mid-ALARM -> all outputs at reset values next cycle.
